// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - PC, IF/ID and ID/EX control stage owner with load-use bubble and branch flush
// Registers here feed ex_mem_read/ex_rd back to the hazard detector, closing the stall loop.
module pipe_stall_ctrl #(
  parameter int          PC_W         = 32,
  parameter int          INSTR_W      = 32,
  parameter int          CTRL_W       = 12,
  parameter int          MEM_READ_BIT = 0,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bubble,
  input  logic [15:0]        pc_offset,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic [CTRL_W-1:0]  id_ctrl,
  input  logic [4:0]         id_rd,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [CTRL_W-1:0]  ex_ctrl,
  output logic [4:0]         ex_rd,
  output logic               ex_mem_read,
  output logic               flush_active,
  output logic [15:0]        bubble_cnt,
  output logic [15:0]        flush_cnt
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_BUBBLE = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  logic [1:0]      state;
  logic            take_bubble;
  logic            take_branch;
  logic [PC_W-1:0] pc_rewind;

  // Only one bubble per load: a bubble is accepted solely from RUN.
  assign take_bubble = bubble && (state == ST_RUN);
  // The squashed NOP in ID can falsely match ex_rd = 0, so FLUSH ignores branches too.
  assign take_branch = branch_taken && !take_bubble && (state != ST_FLUSH);
  assign pc_rewind   = pc + PC_W'(4) - PC_W'(pc_offset);

  assign ex_mem_read  = ex_ctrl[MEM_READ_BIT];
  assign flush_active = (state == ST_FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      if_id_pc    <= '0;
      if_id_instr <= '0;
      ex_ctrl     <= '0;
      ex_rd       <= '0;
      bubble_cnt  <= '0;
      flush_cnt   <= '0;
    end else if (take_bubble) begin
      state   <= ST_BUBBLE;
      pc      <= pc_rewind;
      ex_ctrl <= '0;
      ex_rd   <= '0;
      if (bubble_cnt != 16'hFFFF) begin
        bubble_cnt <= bubble_cnt + 16'd1;
      end
    end else if (take_branch) begin
      state       <= ST_FLUSH;
      pc          <= branch_target;
      if_id_pc    <= '0;
      if_id_instr <= '0;
      ex_ctrl     <= id_ctrl;
      ex_rd       <= id_rd;
      if (flush_cnt != 16'hFFFF) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end else begin
      state       <= ST_RUN;
      pc          <= pc + PC_W'(4);
      if_id_pc    <= pc;
      if_id_instr <= if_instr;
      ex_ctrl     <= id_ctrl;
      ex_rd       <= id_rd;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed and randomized self-checking bench for pipe_stall_ctrl
// The reference model applies the bubble/branch/advance rules with plain arithmetic each cycle.
module tb_pipe_stall_ctrl;

  logic        clk;
  logic        rst;
  logic        bubble;
  logic [15:0] pc_offset;
  logic [31:0] if_instr;
  logic [11:0] id_ctrl;
  logic [4:0]  id_rd;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [11:0] ex_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        flush_active;
  logic [15:0] bubble_cnt;
  logic [15:0] flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 = running, 1 = just stalled, 2 = just flushed.
  int          m_mode;
  logic [31:0] m_pc, m_ifpc, m_ifi;
  logic [11:0] m_ex;
  logic [4:0]  m_rd;
  int          m_bc, m_fc;

  pipe_stall_ctrl #(
    .PC_W(32), .INSTR_W(32), .CTRL_W(12), .MEM_READ_BIT(0), .RESET_PC(32'h400)
  ) dut (
    .clk(clk), .rst(rst), .bubble(bubble), .pc_offset(pc_offset),
    .if_instr(if_instr), .id_ctrl(id_ctrl), .id_rd(id_rd),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .flush_active(flush_active), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 32'h400;
    m_ifpc = 0;
    m_ifi  = 0;
    m_ex   = 0;
    m_rd   = 0;
    m_bc   = 0;
    m_fc   = 0;
  endtask

  task automatic model_step();
    if (m_mode == 0 && bubble) begin
      m_pc = m_pc + 32'd4 - {16'd0, pc_offset};
      m_ex = 0;
      m_rd = 0;
      m_bc = (m_bc < 65535) ? m_bc + 1 : 65535;
      m_mode = 1;
    end else if (branch_taken && m_mode != 2) begin
      m_pc   = branch_target;
      m_ifpc = 0;
      m_ifi  = 0;
      m_ex   = id_ctrl;
      m_rd   = id_rd;
      m_fc   = (m_fc < 65535) ? m_fc + 1 : 65535;
      m_mode = 2;
    end else begin
      m_ifpc = m_pc;
      m_ifi  = if_instr;
      m_pc   = m_pc + 32'd4;
      m_ex   = id_ctrl;
      m_rd   = id_rd;
      m_mode = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".pc"}, 64'(pc), 64'(m_pc));
    chk({tag, ".if_id_pc"}, 64'(if_id_pc), 64'(m_ifpc));
    chk({tag, ".if_id_instr"}, 64'(if_id_instr), 64'(m_ifi));
    chk({tag, ".ex_ctrl"}, 64'(ex_ctrl), 64'(m_ex));
    chk({tag, ".ex_rd"}, 64'(ex_rd), 64'(m_rd));
    chk({tag, ".ex_mem_read"}, 64'(ex_mem_read), 64'(m_ex[0]));
    chk({tag, ".flush_active"}, 64'(flush_active), 64'(m_mode == 2));
    chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(m_bc));
    chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(m_fc));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    bubble = 0; pc_offset = 16'd4; branch_taken = 0; branch_target = 0;
    id_ctrl = 0; id_rd = 0; if_instr = $urandom;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    compare_all("reset");
    chk("reset.pc_const", 64'(pc), 64'h400);
    rst = 0;

    // 1: three clean cycles
    for (int i = 0; i < 3; i++) begin
      if_instr = $urandom;
      step("run");
    end
    chk("t1.pc", 64'(pc), 64'h40C);
    chk("t1.if_id_pc", 64'(if_id_pc), 64'h408);

    // 2: set up pc=0x100 with a load in EX, then stall once
    branch_taken = 1; branch_target = 32'hFC;
    step("t2.jump");
    branch_taken = 0; id_ctrl = 12'h001; id_rd = 5'd7; if_instr = 32'h8C07_0000;
    step("t2.lw");
    chk("t2.pc_pre", 64'(pc), 64'h100);
    chk("t2.ifpc_pre", 64'(if_id_pc), 64'hFC);
    chk("t2.lw_in_ex", 64'(ex_mem_read), 64'd1);
    bubble = 1; pc_offset = 16'd4; id_ctrl = 12'h0A5; id_rd = 5'd3;
    step("t2.bubble");
    chk("t2.pc_hold", 64'(pc), 64'h100);
    chk("t2.ifpc_hold", 64'(if_id_pc), 64'hFC);
    chk("t2.ex_nop", 64'(ex_ctrl), 64'd0);
    chk("t2.bcnt", 64'(bubble_cnt), 64'd1);
    step("t2.bubble_again");
    chk("t2.pc_adv", 64'(pc), 64'h104);
    chk("t2.bcnt_same", 64'(bubble_cnt), 64'd1);
    bubble = 0;

    // 3: taken branch from RUN, then hazards ignored during FLUSH
    branch_taken = 1; branch_target = 32'h2000; id_ctrl = 12'h010;
    step("t3.branch");
    chk("t3.pc", 64'(pc), 64'h2000);
    chk("t3.instr_nop", 64'(if_id_instr), 64'd0);
    chk("t3.flush", 64'(flush_active), 64'd1);
    chk("t3.fcnt", 64'(flush_cnt), 64'd2);
    bubble = 1; branch_target = 32'h5000;
    step("t3.in_flush");
    chk("t3.pc_ign", 64'(pc), 64'h2004);
    chk("t3.flush_off", 64'(flush_active), 64'd0);
    chk("t3.bcnt_same", 64'(bubble_cnt), 64'd1);

    // 4: simultaneous bubble and branch in RUN, bubble wins
    bubble = 1; branch_taken = 1; branch_target = 32'h3000; pc_offset = 16'd4;
    step("t4.both");
    chk("t4.pc_hold", 64'(pc), 64'h2004);
    chk("t4.ex_nop", 64'(ex_ctrl), 64'd0);
    bubble = 0;
    step("t4.branch");
    chk("t4.pc_tgt", 64'(pc), 64'h3000);
    chk("t4.fcnt", 64'(flush_cnt), 64'd3);
    idle_inputs();
    step("t4.settle");

    // 5: counter saturation, then async reset mid-BUBBLE
    force dut.bubble_cnt = 16'hFFFE;
    #1;
    release dut.bubble_cnt;
    m_bc = 32'hFFFE;
    for (int i = 0; i < 3; i++) begin
      bubble = 1; pc_offset = 16'd8;
      step("t5.bubble");
      bubble = 0;
      if (i < 2) begin
        step("t5.gap1");
        step("t5.gap2");
      end
    end
    chk("t5.sat", 64'(bubble_cnt), 64'hFFFF);
    #1;
    rst = 1;
    #1;
    model_reset();
    compare_all("t5.async_rst");
    @(posedge clk);
    #1;
    rst = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bubble        = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 4) == 0);
      branch_target = $urandom;
      case ($urandom_range(0, 3))
        0: pc_offset = 16'd4;
        1: pc_offset = 16'd0;
        2: pc_offset = 16'd8;
        default: pc_offset = 16'($urandom);
      endcase
      if_instr = $urandom;
      id_ctrl  = 12'($urandom);
      id_rd    = 5'($urandom);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
